// File: rtl/clock_pkg.sv
// Shared calendar types and helpers for the Millennium Clock counter chain.
// Contents:
//   bcd_t              one BCD digit
//   JAN..DEC           month numbers as two-digit BCD {ten, unit}
//   DAYS_28..DAYS_31   month lengths as two-digit BCD {ten, unit}
//   bcd_div4()         divisible-by-4 test on a two-digit BCD number
`timescale 1ns/1ps
package clock_pkg;

    typedef logic [3:0] bcd_t;

    localparam logic [7:0] JAN = 8'h01;
    localparam logic [7:0] FEB = 8'h02;
    localparam logic [7:0] MAR = 8'h03;
    localparam logic [7:0] APR = 8'h04;
    localparam logic [7:0] MAY = 8'h05;
    localparam logic [7:0] JUN = 8'h06;
    localparam logic [7:0] JUL = 8'h07;
    localparam logic [7:0] AUG = 8'h08;
    localparam logic [7:0] SEP = 8'h09;
    localparam logic [7:0] OCT = 8'h10;
    localparam logic [7:0] NOV = 8'h11;
    localparam logic [7:0] DEC = 8'h12;

    localparam logic [7:0] DAYS_28 = 8'h28;
    localparam logic [7:0] DAYS_29 = 8'h29;
    localparam logic [7:0] DAYS_30 = 8'h30;
    localparam logic [7:0] DAYS_31 = 8'h31;

    // A number 10*t+u is divisible by 4 iff (2*t+u) is, so the parity of the
    // ten digit selects which unit digits qualify.
    function automatic logic bcd_div4(input bcd_t ten, input bcd_t unit);
        if (ten[0])
            return (unit == 4'd2) || (unit == 4'd6);
        else
            return (unit == 4'd0) || (unit == 4'd4) || (unit == 4'd8);
    endfunction

endpackage

// File: rtl/month_length.sv
// Combinational month length lookup: current month/year -> last day (BCD).
// Build option: COUNTER_DAYS_LEAP_YEAR_EN enables Gregorian leap years;
// without it February is always 28 days and the year digits are ignored.
// Ports:
//   month_unit, month_ten   in   month in BCD
//   year_*                  in   year in BCD (thousands..units)
//   max_day                 out  last valid day of the month, BCD {ten, unit}
`timescale 1ns/1ps
module month_length
    import clock_pkg::*;
(
    input  bcd_t       month_unit,
    input  bcd_t       month_ten,
    input  bcd_t       year_unit,
    input  bcd_t       year_ten,
    input  bcd_t       year_hund,
    input  bcd_t       year_thou,
    output logic [7:0] max_day
);

    logic w_leap;

`ifdef COUNTER_DAYS_LEAP_YEAR_EN
    // Century years (yy = 00) are leap only when the century itself is
    // divisible by 4, e.g. 2000 yes, 1900 no.
    always_comb begin
        w_leap = 1'b0;
        if ({year_ten, year_unit} != 8'h00)
            w_leap = bcd_div4(year_ten, year_unit);
        else
            w_leap = bcd_div4(year_thou, year_hund);
    end
`else
    logic w_unused_year;

    assign w_leap        = 1'b0;
    assign w_unused_year = ^{year_thou, year_hund, year_ten, year_unit};
`endif

    // Invalid months (00, >12, non-BCD digits) fall to the default of 31 so
    // the counter always has a sane limit.
    always_comb begin
        max_day = DAYS_31;
        case ({month_ten, month_unit})
            JAN, MAR, MAY, JUL, AUG, OCT, DEC: max_day = DAYS_31;
            APR, JUN, SEP, NOV:                max_day = DAYS_30;
            FEB:                               max_day = w_leap ? DAYS_29 : DAYS_28;
            default:                           max_day = DAYS_31;
        endcase
    end

endmodule

// File: rtl/counter_days.sv
// Day-of-month counter (two-digit BCD) for the Millennium Clock calendar.
// Advances on tick_day in run mode, or steps up/down in set mode, and emits
// a registered one-cycle tick_month when the day wraps from the last day to 01.
// Build option: COUNTER_DAYS_LEAP_YEAR_EN (see month_length).
// Ports:
//   clk, rst              in   clock, asynchronous active-high reset
//   mode_day              in   1 = run (count on tick_day), 0 = set (up/down)
//   up, down              in   set-mode stepping levels
//   tick_day              in   run-mode advance enable
//   month_unit/ten        in   current month, BCD
//   year_unit..year_thou  in   current year, BCD
//   day_unit, day_ten     out  current day, BCD 01..max
//   tick_month            out  end-of-month pulse
`timescale 1ns/1ps
module counter_days
    import clock_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic mode_day,
    input  logic up,
    input  logic down,
    input  logic tick_day,
    input  bcd_t month_unit,
    input  bcd_t month_ten,
    input  bcd_t year_unit,
    input  bcd_t year_ten,
    input  bcd_t year_hund,
    input  bcd_t year_thou,
    output bcd_t day_unit,
    output bcd_t day_ten,
    output logic tick_month
);

    bcd_t       r_day_ten;
    bcd_t       r_day_unit;
    logic       r_tick_month;

    logic [7:0] w_max_day;
    logic [7:0] w_day;
    logic [7:0] w_day_inc;
    logic [7:0] w_day_dec;
    logic       w_at_max;
    logic       w_at_min;
    logic       w_over_max;

    month_length u_month_length (
        .month_unit (month_unit),
        .month_ten  (month_ten),
        .year_unit  (year_unit),
        .year_ten   (year_ten),
        .year_hund  (year_hund),
        .year_thou  (year_thou),
        .max_day    (w_max_day)
    );

    // BCD ordering matches numeric ordering, so plain 8-bit compares work.
    assign w_day      = {r_day_ten, r_day_unit};
    assign w_at_max   = (w_day == w_max_day);
    assign w_at_min   = (w_day == 8'h01);
    assign w_over_max = (w_day > w_max_day);

    always_comb begin
        w_day_inc = w_day;
        if (w_at_max)
            w_day_inc = 8'h01;
        else if (r_day_unit == 4'd9)
            w_day_inc = {r_day_ten + 4'd1, 4'd0};
        else
            w_day_inc = {r_day_ten, r_day_unit + 4'd1};
    end

    always_comb begin
        w_day_dec = w_day;
        if (w_at_min)
            w_day_dec = w_max_day;
        else if (r_day_unit == 4'd0)
            w_day_dec = {r_day_ten - 4'd1, 4'd9};
        else
            w_day_dec = {r_day_ten, r_day_unit - 4'd1};
    end

    // Clamp first: a month/year change can leave the day beyond the new
    // month end; pulling it back is not a rollover, so no tick_month.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_day_ten    <= 4'd0;
            r_day_unit   <= 4'd1;
            r_tick_month <= 1'b0;
        end else begin
            r_tick_month <= 1'b0;
            if (w_over_max) begin
                {r_day_ten, r_day_unit} <= w_max_day;
            end else if (mode_day) begin
                if (tick_day) begin
                    {r_day_ten, r_day_unit} <= w_day_inc;
                    r_tick_month            <= w_at_max;
                end
            end else if (up && !down) begin
                {r_day_ten, r_day_unit} <= w_day_inc;
            end else if (down && !up) begin
                {r_day_ten, r_day_unit} <= w_day_dec;
            end
        end
    end

    assign day_ten    = r_day_ten;
    assign day_unit   = r_day_unit;
    assign tick_month = r_tick_month;

endmodule

// File: tb/tb_counter_days.sv
`timescale 1ns/1ps
module tb_counter_days;

    logic        clk;
    logic        rst;
    logic        mode_day;
    logic        up;
    logic        down;
    logic        tick_day;
    logic [7:0]  month;
    logic [15:0] year;
    logic [3:0]  day_unit;
    logic [3:0]  day_ten;
    logic        tick_month;

    int checks;
    int errors;

    counter_days dut (
        .clk        (clk),
        .rst        (rst),
        .mode_day   (mode_day),
        .up         (up),
        .down       (down),
        .tick_day   (tick_day),
        .month_unit (month[3:0]),
        .month_ten  (month[7:4]),
        .year_unit  (year[3:0]),
        .year_ten   (year[7:4]),
        .year_hund  (year[11:8]),
        .year_thou  (year[15:12]),
        .day_unit   (day_unit),
        .day_ten    (day_ten),
        .tick_month (tick_month)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        mode;
        logic        up;
        logic        down;
        logic        tick;
        logic [7:0]  month;
        logic [15:0] year;
        logic [7:0]  exp_day;
        logic        exp_tick;
    } vec_t;

    vec_t vecs [30];

    function automatic logic [7:0] to_bcd(input int n);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(n / 10);
        u = 4'(n % 10);
        return {t, u};
    endfunction

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic [7:0] exp_day, input logic exp_tick);
        chk({name, " day"}, {day_ten, day_unit}, exp_day);
        chk({name, " tick"}, {7'd0, tick_month}, {7'd0, exp_tick});
    endtask

    task automatic step(input logic m, input logic u, input logic d, input logic t,
                        input logic [7:0] mon, input logic [15:0] yr);
        mode_day = m;
        up       = u;
        down     = d;
        tick_day = t;
        month    = mon;
        year     = yr;
        @(posedge clk);
        #1;
    endtask

    // From day 01: January, step down to 31, 30, 29, 28.
    task automatic goto28();
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 16'h2023);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 16'h2023);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 16'h2023);
        step(1'b0, 1'b0, 1'b1, 1'b0, 8'h01, 16'h2023);
        chk_out("goto28", 8'h28, 1'b0);
    endtask

    task automatic feb_case(input logic [15:0] yr, input logic leap_if_enabled);
        logic leap;
`ifdef COUNTER_DAYS_LEAP_YEAR_EN
        leap = leap_if_enabled;
`else
        leap = 1'b0;
`endif
        goto28();
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h02, yr);
        if (leap) begin
            chk_out("feb leap 28->29", 8'h29, 1'b0);
            step(1'b1, 1'b0, 1'b0, 1'b1, 8'h02, yr);
            chk_out("feb leap 29->01", 8'h01, 1'b1);
        end else begin
            chk_out("feb common 28->01", 8'h01, 1'b1);
        end
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, yr);
        chk_out("feb pulse end", 8'h01, 1'b0);
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        mode_day = 1'b0;
        up       = 1'b0;
        down     = 1'b0;
        tick_day = 1'b0;
        month    = 8'h01;
        year     = 16'h2024;

        // mode, up, down, tick, month, year, expected day, expected tick
        vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 16'h2023, 8'h30, 1'b0};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 16'h2023, 8'h29, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 16'h2023, 8'h28, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h04, 16'h2023, 8'h28, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h04, 16'h2023, 8'h28, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h04, 16'h2023, 8'h28, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h04, 16'h2023, 8'h28, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h04, 16'h2023, 8'h28, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h04, 16'h2023, 8'h28, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h04, 16'h2023, 8'h29, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h04, 16'h2023, 8'h30, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h04, 16'h2023, 8'h01, 1'b0};
        vecs[12] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h04, 16'h2023, 8'h30, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h05, 16'h2023, 8'h31, 1'b0};
        vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h06, 16'h2023, 8'h30, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 8'h02, 16'h2023, 8'h28, 1'b0};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 16'h2023, 8'h01, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h06, 16'h2023, 8'h01, 1'b0};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h13, 16'h2023, 8'h02, 1'b0};
        vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h13, 16'h2023, 8'h01, 1'b0};
        vecs[20] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h13, 16'h2023, 8'h31, 1'b0};
        vecs[21] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h13, 16'h2023, 8'h01, 1'b1};
        vecs[22] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h13, 16'h2023, 8'h01, 1'b0};
        vecs[23] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 16'h2023, 8'h31, 1'b0};
        vecs[24] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h1A, 16'h2023, 8'h01, 1'b0};
        vecs[25] = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h05, 16'h2023, 8'h02, 1'b0};
        vecs[26] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 16'h2023, 8'h01, 1'b0};
        vecs[27] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h05, 16'h2023, 8'h31, 1'b0};
        vecs[28] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 16'h2023, 8'h30, 1'b0};
        vecs[29] = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h04, 16'h2023, 8'h01, 1'b1};

        // Reset state and idle hold after release
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_out("reset", 8'h01, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 16'h2024);
            chk_out("idle hold", 8'h01, 1'b0);
        end

        // January run: 30 edges to reach 31, wrap on the 31st
        for (int i = 1; i <= 30; i++) begin
            step(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 16'h2024);
            chk_out("jan count", to_bcd(i + 1), 1'b0);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 16'h2024);
        chk_out("jan wrap", 8'h01, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 16'h2024);
        chk_out("jan after wrap", 8'h02, 1'b0);
        for (int i = 0; i < 15; i++)
            step(1'b1, 1'b0, 1'b0, 1'b1, 8'h01, 16'h2024);
        chk_out("jan day 17", 8'h17, 1'b0);

        // Asynchronous reset mid-count, checked before the next edge
        rst = 1'b1;
        #1;
        chk_out("async reset mid-count", 8'h01, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 16'h2024);
        chk_out("hold after reset", 8'h01, 1'b0);

        // Table-driven set mode, clamp, invalid months, priority
        for (int i = 0; i < 30; i++) begin
            step(vecs[i].mode, vecs[i].up, vecs[i].down, vecs[i].tick,
                 vecs[i].month, vecs[i].year);
            chk({"vec day ", $sformatf("%0d", i)}, {day_ten, day_unit}, vecs[i].exp_day);
            chk({"vec tick ", $sformatf("%0d", i)}, {7'd0, tick_month}, {7'd0, vecs[i].exp_tick});
        end

        // February across the leap-year rules
        feb_case(16'h2024, 1'b1);
        feb_case(16'h1900, 1'b0);
        feb_case(16'h2000, 1'b1);
        feb_case(16'h2100, 1'b0);
        feb_case(16'h2400, 1'b1);
        feb_case(16'h2023, 1'b0);
        feb_case(16'h2096, 1'b1);
        feb_case(16'h2010, 1'b0);
        feb_case(16'h2012, 1'b1);

        // Reset while tick_month is pending
        goto28();
        step(1'b1, 1'b0, 1'b0, 1'b1, 8'h02, 16'h2023);
        chk_out("wrap before reset", 8'h01, 1'b1);
        rst = 1'b1;
        #1;
        chk_out("reset kills tick", 8'h01, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/counter_days.md
# counter_days

Day-of-month counter for the Millennium Clock calendar chain. It sits directly upstream of `counter_months`. It counts days in two-digit BCD, advancing on `tick_day` from the hours stage or by manual up/down stepping. It produces the single-cycle `tick_month` that drives `counter_months`. The month length comes from the current month and year digits, including Gregorian leap-year handling.

## Interface
Parameters:
- none; all limits are fixed calendar constants.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `mode_day`  in  1  1 = run mode (count on `tick_day`); 0 = set mode (`up`/`down` stepping).
- `up`  in  1  set-mode increment request, level, acted on every clock.
- `down`  in  1  set-mode decrement request, level, acted on every clock.
- `tick_day`  in  1  run-mode day-advance enable, one step per clock while high.
- `month_unit`, `month_ten`  in  4 each  current month in BCD, from `counter_months`.
- `year_unit`, `year_ten`, `year_hund`, `year_thou`  in  4 each  current year in BCD.
- `day_unit`, `day_ten`  out  4 each  current day in BCD, range 01..max.
- `tick_month`  out  1  registered one-cycle pulse on end-of-month rollover.

## Operation
- Reset values: `day_ten`=0, `day_unit`=1 (day 01), `tick_month`=0.
- `max_day` by month:
  - 31 for months 01, 03, 05, 07, 08, 10, 12.
  - 30 for months 04, 06, 09, 11.
  - 28 or 29 for month 02.
  - 31 for any invalid month: 00, >12, or a non-BCD digit.
- Leap year:
  - Last two digits `yy` ≠ 00: leap iff `yy` divisible by 4.
  - `yy` = 00: leap iff the century digits `year_thou:year_hund` are divisible by 4.
  - BCD divisibility by 4: ten digit even with unit in {0,4,8}, or ten digit odd with unit in {2,6}.
- Per-edge priority, highest first:
  1. Clamp: if current day > `max_day`, load `max_day`. No `tick_month`. This covers a month or year change while the day is out of range.
  2. Run mode (`mode_day`=1): if `tick_day`=1, increment. At `max_day`, wrap to 01 and set `tick_month` for the next cycle. `up`/`down` are ignored.
  3. Set mode (`mode_day`=0):
     - `up`=1 and `down`=0: increment, `max_day` wraps to 01.
     - `down`=1 and `up`=0: decrement, 01 wraps to `max_day`.
     - Both set or neither set: hold.
     - Set mode never asserts `tick_month`; `tick_day` is ignored.
- Increment is BCD: unit 9 → 0 with ten+1.
- Decrement is BCD: unit 0 → 9 with ten−1.
- Day 00 and non-BCD digits are never produced.

## Timing
- Count latency: one clock. The edge that samples the request updates `day_*`.
- `tick_month`:
  - High for exactly the one cycle after the edge that wrapped the day to 01.
  - With `tick_day` held high continuously, the pulse still lasts one cycle per wrap.
- `max_day` is combinational from the current month/year inputs. Month changes take effect on the very next edge.
- An asserted `rst` forces the reset values immediately and overrides everything, including in the middle of a rollover or a pending `tick_month`.

## Configuration
- `COUNTER_DAYS_LEAP_YEAR_EN`
  - Defined: February is 29 days in leap years, per the rule above.
  - Undefined: February is always 28 days, and the four year inputs are unused (left in the port list, ignored).

## Structure
- Shared package `clock_pkg`:
  - BCD digit typedef.
  - Month constants `JAN`..`DEC`.
  - Day-count constants 28/29/30/31.
  - BCD divisible-by-4 helper function, shared with the year counter.
- Sub-module `month_length`: combinational month/year → `max_day` (BCD), containing the leap-year logic and the `COUNTER_DAYS_LEAP_YEAR_EN` guard.
- `counter_days` holds the BCD state registers, priority logic and the `tick_month` register.

## Test plan
- Reset: `rst`=1 mid-count at day 17 → outputs 01/0 immediately. After release with no inputs, the day holds at 01.
- Month 01, run mode, `tick_day` high 31 clocks from 01:
  - Day reaches 31 after 30 edges.
  - 31st edge → 01.
  - `tick_month`=1 for exactly one cycle.
- Month 02 with macro defined:
  - Year 2024: 28 → 29 → 01 plus `tick_month`.
  - Year 1900: 28 → 01.
  - Year 2000: 28 → 29.
  - Macro undefined, year 2024: 28 → 01.
- Month 04, set mode, `down`=1 from 01 → 30, 29, 28; no `tick_month`. Then `up`=`down`=1 for 5 clocks → holds at 28.
- Clamp: day 31, month input changed 05 → 06 → day 30 on the next edge, no `tick_month`. Then month 02, year 2023 → day 28 on the next edge.
- Invalid month 13, run mode: counts to 31 then wraps to 01 with `tick_month`.
